// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the round-robin mux arbiter.
package mux_arb_pkg;

   // Number of requesters; also the input count of the shared mux.
   localparam int N        = 8;
   // Width of the binary select driven onto the mux S input.
   localparam int SEL_W    = 3;
   // Default watchdog limit in cycles, used only when the watchdog is built.
   localparam int MAX_HOLD = 16;

   // Arbiter control states.
   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Rotated-priority picker: finds the first set request bit strictly after
// ptr, wrapping around, so the last owner has the lowest priority.
// N must be a power of two so that SEL_W-bit addition wraps modulo N.
module rr_pick #(
   parameter int N     = mux_arb_pkg::N,
   parameter int SEL_W = mux_arb_pkg::SEL_W
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] idx,
   output logic             any_req
);

   logic [SEL_W-1:0] pos;
   logic             found;

   // Walk ptr+1 .. ptr+N (mod N) and keep the first requester hit.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int i = 1; i <= N; i++) begin
         pos = ptr + SEL_W'(i);
         if (!found && req[pos]) begin
            idx   = pos;
            found = 1'b1;
         end
      end
   end

   assign any_req = |req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares one mux_8X1 datapath among N requesters.
// A grant is held until the owner pulses done or drops its request, and a
// one-cycle idle bubble always separates consecutive grants. sel drives the
// mux S input directly.
// Optional watchdog: define MUX_ARB_TIMEOUT_EN to force release of a grant
// held for MAX_HOLD cycles and pulse timeout; without it timeout is tied 0.
module mux_rr_arbiter #(
   parameter int N        = mux_arb_pkg::N,
   parameter int SEL_W    = mux_arb_pkg::SEL_W,
   parameter int MAX_HOLD = mux_arb_pkg::MAX_HOLD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] sel,
   output logic             gnt_valid,
   output logic             timeout
);

   import mux_arb_pkg::*;

   // The picker relies on SEL_W-bit wrap-around, and the watchdog needs at
   // least one full GRANT cycle before it can fire.
   if (N != (1 << SEL_W)) begin : g_bad_width
      $error("mux_rr_arbiter: N must equal 2**SEL_W");
   end
   if (MAX_HOLD < 2) begin : g_bad_hold
      $error("mux_rr_arbiter: MAX_HOLD must be at least 2");
   end

   state_t           state;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_any;
   logic             force_rel;
   logic             release_now;

   // One-hot decode of a requester index.
   function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   rr_pick #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .idx     (pick_idx),
      .any_req (pick_any)
   );

   // Only the owner's request line matters while a grant is held.
   assign release_now = done | ~req[sel] | force_rel;

   // Arbitration FSM with registered grant outputs and rotating pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= SEL_W'(N - 1);
         gnt       <= '0;
         sel       <= '0;
         gnt_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt       <= onehot(pick_idx);
                  sel       <= pick_idx;
                  gnt_valid <= 1'b1;
                  ptr       <= pick_idx;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  gnt       <= '0;
                  gnt_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               gnt       <= '0;
               gnt_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef MUX_ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD);

   logic [HOLD_W-1:0] hold_cnt;

   // The watchdog fires only when no natural release happens this cycle.
   assign force_rel = (state == GRANT) &&
                      (hold_cnt == HOLD_W'(MAX_HOLD - 1)) &&
                      !done && req[sel];

   // Hold counter (zero in IDLE, so zero on GRANT entry) and timeout pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         if (state == IDLE) begin
            hold_cnt <= '0;
         end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            if (force_rel) begin
               timeout <= 1'b1;
            end
         end
      end
   end
`else
   assign force_rel = 1'b0;
   assign timeout   = 1'b0;
`endif

   // Grant must never be multi-hot.
   a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
      $onehot0(gnt));

   // gnt_valid mirrors a non-zero grant.
   a_valid_match : assert property (@(posedge clk) disable iff (rst)
      gnt_valid == (gnt != '0));

   // The mux select must not move under an active grant.
   a_sel_stable : assert property (@(posedge clk) disable iff (rst)
      (gnt_valid && $past(gnt_valid)) |-> (sel == $past(sel)));

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter sharing one mux_8X1 datapath among 8 requesters.
- Arbitrates the req lines, holds a grant until the owner signals done, and drives the mux select S directly from sel.
- Sits between the requesting agents and the mux_8X1 instance; sel feeds S, gnt returns ownership to the agents.

Parameters:
N, 8, number of requesters (equals mux input count)
SEL_W, 3, select width, log2(N)
MAX_HOLD, 16, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req  input  N  per-requester request, level, held high until granted and served
done  input  1  current owner releases the mux (single-cycle pulse)
gnt  output  N  one-hot grant, registered
sel  output  SEL_W  binary index of granted requester, drives mux S
gnt_valid  output  1  high while a grant is held
timeout  output  1  watchdog release pulse (tied 0 without the feature)

Behaviour:
- Reset (async, active-high): gnt=0, sel=0, gnt_valid=0, timeout=0, state=IDLE, ptr=N-1, so requester 0 has first priority.
- States:
  - IDLE: if req!=0, pick the first set bit searching from ptr+1 upward with wrap-around (ptr+1 … N-1, 0 … ptr). Next edge: gnt=onehot(idx), sel=idx, gnt_valid=1, ptr=idx, go to GRANT. Latency is 1 clock from req seen to gnt.
  - IDLE with req==0: outputs stay 0, sel holds its last value.
  - GRANT: hold gnt/sel stable. Release when done=1 or req[sel]=0. Next edge: gnt=0, gnt_valid=0, go to IDLE.
- Mandatory one-cycle bubble between consecutive grants: no back-to-back re-arbitration.
- done in IDLE is ignored.
- done and new requests in the same cycle: release takes priority; the new requests are arbitrated in the following IDLE cycle.
- Only the owner's req is checked in GRANT; changes on other req bits are ignored until IDLE.
- sel never changes while gnt_valid=1.
- gnt is always zero or one-hot; it is never multi-hot.
- rst mid-grant: immediate clear to reset values, ptr returns to N-1.
- Fairness: a continuously requesting agent is granted within N grants.

Optional Feature:
- Macro: MUX_ARB_TIMEOUT_EN.
- With the macro:
  - A hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If the count reaches MAX_HOLD-1 without done, force release on the next edge (same as done) and pulse timeout=1 for exactly that one cycle.
  - The counter is cleared by reset.
- Without the macro: no counter logic, timeout is constant 0, and a grant is held indefinitely until done or req drop.

Decomposition:
- Package mux_arb_pkg:
  - N, SEL_W constants.
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - MAX_HOLD default.
- One sub-module rr_pick:
  - Combinational; inputs req[N-1:0] and ptr[SEL_W-1:0].
  - Outputs idx[SEL_W-1:0] and any_req.
  - Rotated priority search.
- Top level keeps the FSM, registers and watchdog.

Test Plan:
- Reset then req=8'b0000_0001: gnt=8'b0000_0001, sel=0, gnt_valid=1 one clock later; done pulse: gnt=0 next clock.
- req=8'b1000_0001 held, done after each grant: grants alternate 0,7,0,7; sel matches; one idle cycle between grants.
- req=8'hFF held, done each grant: sel sequence 0,1,2,…,7,0 (fairness wrap-around).
- While sel=3 is granted, toggle req[5]: gnt and sel unchanged. Drop req[3]: release next clock.
- Assert rst mid-grant at sel=4 with req=8'h10: outputs 0 immediately. After rst deasserts with req=8'h11, first grant is sel=0.
- With MUX_ARB_TIMEOUT_EN, MAX_HOLD=16, req=8'h04, no done: gnt holds 16 cycles, then timeout pulses 1 cycle, gnt=0, then regrant to 2 after the bubble. Without the macro: grant holds for 100 cycles and timeout stays 0.
